stage_sequencer: RTL and testbench

Parametrised multi-cycle instruction sequencer that replaces the derived per-phase clocks with one-hot stage enables on the single core clock. It steps an instruction through NUM_STAGES phases (default FT/DC/EX/MA/WB). It stalls in the memory stage on a ready handshake and in the execute stage on a busy/done handshake from extension units such as the AES engines. It counts retired instructions and drives the phase enables for the PC, register file, MMU and extension blocks.

---
 rtl/core_pkg.sv | 9 +
 rtl/wait_timer.sv | 18 +
 rtl/stage_sequencer.sv | 90 +++++++++
 tb/tb_stage_sequencer.sv | 111 +++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared sequencer state encoding and default stage indices.
package core_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_MEM, WAIT_EXT} state_e;
  localparam int STG_FT = 0;
  localparam int STG_DC = 1;
  localparam int STG_EX = 2;
  localparam int STG_MA = 3;
  localparam int STG_WB = 4;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: counts consecutive wait cycles and flags the cycle the limit is reached.
module wait_timer #(
  parameter int LIMIT = 255,
  localparam int CW = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic expired_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = run_i ? CW'(cnt_q + 1'b1) : '0;
  assign expired_o = run_i && cnt_q == CW'(LIMIT - 1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: one-hot phase-enable sequencer with memory/extension stalls.
// Define STAGE_TIMEOUT_EN to bound waits with TIMEOUT_CYCLES and a sticky fault.
module stage_sequencer
  import core_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int MEM_STAGE = STG_MA,
  parameter int EXT_STAGE = STG_EX,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDXW = $clog2(NUM_STAGES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  ext_req,
  input  logic                  ext_done,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [IDXW-1:0]       stage_idx,
  output logic                  mem_stall,
  output logic                  ext_stall,
  output logic                  retire,
  output logic [31:0]           instret,
  output logic                  fault
);
  if (NUM_STAGES < 2 || MEM_STAGE == EXT_STAGE || MEM_STAGE >= NUM_STAGES || EXT_STAGE >= NUM_STAGES) begin : g_bad_cfg
    $error("stage_sequencer: invalid stage configuration");
  end
  state_e state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [31:0] instret_q;
  logic fault_q, fault_d;
  logic last, go_mem, go_ext, adv, expired;
  assign last = idx_q == IDXW'(NUM_STAGES - 1);
  assign go_mem = state_q == ACTIVE && idx_q == IDXW'(MEM_STAGE) && mem_req && !mem_ready;
  assign go_ext = state_q == ACTIVE && idx_q == IDXW'(EXT_STAGE) && ext_req && !ext_done;
  // adv marks the cycle in which the current stage completes
  assign adv = state_q == ACTIVE   ? !(go_mem || go_ext) :
               state_q == WAIT_MEM ? mem_ready :
               state_q == WAIT_EXT ? ext_done : 1'b0;
`ifdef STAGE_TIMEOUT_EN
  wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait_timer (
    .clk      (CLK),
    .rst      (RST),
    .run_i    (state_q == WAIT_MEM || state_q == WAIT_EXT),
    .expired_o(expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      instret_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fault_q   <= fault_d;
      instret_q <= retire ? instret_q + 32'd1 : instret_q;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fault_d = fault_q;
    if (state_q == IDLE && run && !fault_q) state_d = ACTIVE;
    else if (go_ext) state_d = WAIT_EXT;
    else if (go_mem) state_d = WAIT_MEM;
    else if (adv) begin
      idx_d   = last ? '0 : IDXW'(idx_q + 1'b1);
      state_d = (!last || run) ? ACTIVE : IDLE;
    end else if (expired) begin
      state_d = IDLE;
      idx_d   = '0;
      fault_d = 1'b1;
    end
  end
  always_comb begin
    stage_en  = state_q == ACTIVE ? NUM_STAGES'(1) << idx_q : '0;
    stage_idx = idx_q;
    mem_stall = state_q == WAIT_MEM;
    ext_stall = state_q == WAIT_EXT;
    retire    = adv && last;
    instret   = instret_q;
    fault     = fault_q;
  end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed stimulus with a per-cycle expected-output scoreboard.
module tb_stage_sequencer;
  logic CLK = 0, RST = 1, run = 0, mem_req = 0, mem_ready = 0, ext_req = 0, ext_done = 0;
  logic [4:0] stage_en;
  logic [2:0] stage_idx;
  logic mem_stall, ext_stall, retire, fault;
  logic [31:0] instret;
  logic [43:0] act;
  typedef struct { string tag; logic [43:0] v; } exp_t;
  exp_t sb[$];
  exp_t e;
  int compared = 0, mismatched = 0;

  stage_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST), .run(run), .mem_req(mem_req), .mem_ready(mem_ready),
    .ext_req(ext_req), .ext_done(ext_done), .stage_en(stage_en), .stage_idx(stage_idx),
    .mem_stall(mem_stall), .ext_stall(ext_stall), .retire(retire), .instret(instret),
    .fault(fault)
  );

  always #5 CLK = ~CLK;
  assign act = {stage_en, stage_idx, mem_stall, ext_stall, retire, instret, fault};

  task automatic cyc(input string tag, input logic r, rn, mq, mr, eq, ed,
                     input logic [4:0] en, input int idx, input logic ms, es, ret,
                     input int ir, input logic flt);
    @(posedge CLK); #1;
    RST = r; run = rn; mem_req = mq; mem_ready = mr; ext_req = eq; ext_done = ed;
    sb.push_back('{tag, {en, 3'(idx), ms, es, ret, 32'(ir), flt}});
  endtask

  task automatic stg(input string tag, input int s, input logic rn, input int ir);
    cyc(tag, 0, rn, 0, 0, 0, 0, 5'(1 << s), s, 0, 0, s == 4, ir, 0);
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compared++;
      if (act !== e.v) begin
        mismatched++;
        $display("FAIL %s: got en=%b idx=%0d ms=%b es=%b ret=%b ir=%0d flt=%b, want en=%b idx=%0d ms=%b es=%b ret=%b ir=%0d flt=%b",
                 e.tag, act[43:39], act[38:36], act[35], act[34], act[33], act[32:1], act[0],
                 e.v[43:39], e.v[38:36], e.v[35], e.v[34], e.v[33], e.v[32:1], e.v[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("idle_run", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 5; s++) stg("seq", s, !(k == 2 && s == 4), k);
    cyc("seq_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);

    cyc("mem_go", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
    for (int s = 0; s < 3; s++) cyc("mem_pre", 0, 1, 1, 0, 0, 0, 5'(1 << s), s, 0, 0, 0, 3, 0);
    cyc("mem_en3", 0, 1, 1, 0, 0, 0, 5'b01000, 3, 0, 0, 0, 3, 0);
    for (int w = 1; w <= 4; w++) cyc("mem_wait", 0, 1, 1, w == 4, 0, 0, 0, 3, 1, 0, 0, 3, 0);
    cyc("mem_en4", 0, 0, 0, 0, 0, 0, 5'b10000, 4, 0, 0, 1, 3, 0);
    cyc("mem_idle", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0);

    cyc("ext_go", 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4, 0);
    for (int s = 0; s < 5; s++)
      cyc("ext_nostall", 0, s != 4, 0, 0, 1, s == 2, 5'(1 << s), s, 0, 0, s == 4, 4, 0);
    cyc("ext_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 5, 0);

    cyc("drain_go", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    for (int s = 0; s < 5; s++) stg("drain", s, s == 0, 5);
    cyc("drain_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    cyc("drain_idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);

    cyc("rw_go", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    stg("rw_s0", 0, 1, 6);
    stg("rw_s1", 1, 1, 6);
    cyc("rw_en2", 0, 1, 0, 0, 1, 0, 5'b00100, 2, 0, 0, 0, 6, 0);
    cyc("rw_wait", 0, 1, 0, 0, 1, 0, 0, 2, 0, 1, 0, 6, 0);
    cyc("rw_wait_rst", 1, 1, 0, 0, 1, 0, 0, 2, 0, 1, 0, 6, 0);
    cyc("rw_after", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("rw_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc("re_go", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 5; s++) stg("re", s, s != 4, 0);
    cyc("re_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

`ifdef STAGE_TIMEOUT_EN
    cyc("to_go", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int s = 0; s < 3; s++) cyc("to_pre", 0, 1, 1, 0, 0, 0, 5'(1 << s), s, 0, 0, 0, 1, 0);
    cyc("to_en3", 0, 1, 1, 0, 0, 0, 5'b01000, 3, 0, 0, 0, 1, 0);
    for (int w = 1; w <= 8; w++) cyc("to_wait", 0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc("to_fault", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("to_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc("to_clear", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stg("to_restart", 0, 1, 0);
`endif

    @(negedge CLK); #1;
    if (sb.size() != 0) $display("FAIL scoreboard: %0d expectations never compared", sb.size());
    if (compared < 12) $display("FAIL coverage: only %0d cycles compared", compared);
    if (mismatched != 0) $display("FAIL result: %0d mismatches", mismatched);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
